// File: rtl/video_ram_pkg.sv
// Shared types and default sizes for the video frame RAM.
// Clear-engine FSM encoding lives here so bench and RTL agree.
package video_ram_pkg;

  localparam int DEF_DATA_WIDTH = 3;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_MEM_SIZE   = 65536;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/video_ram_dp_core.sv
// Plain simple dual-port storage: one write port, registered read.
// No reset on the array so it maps onto block RAM.
module video_ram_dp_core #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_SIZE   = 65536
) (
  input  logic                  Clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  always_ff @(posedge Clock) begin
    if (we)
      mem[waddr[IW-1:0]] <= wdata;
    q <= mem[raddr[IW-1:0]];
  end

endmodule

// File: rtl/video_ram_clear.sv
// Video frame RAM with a hardware clear engine and busy/done handshake.
// Define VIDEORAM_RD_BYPASS_EN to forward same-cycle writes to the read port.
module video_ram_clear
  import video_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_SIZE   = DEF_MEM_SIZE
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iWriteEnable,
  input  logic [ADDR_WIDTH-1:0] iWriteAddress,
  input  logic [DATA_WIDTH-1:0] iDataIn,
  input  logic [ADDR_WIDTH-1:0] iReadAddress,
  output logic [DATA_WIDTH-1:0] oDataOut,
  input  logic                  iClearRequest,
  input  logic [DATA_WIDTH-1:0] iClearColor,
  output logic                  oClearBusy,
  output logic                  oClearDone,
  output logic                  oWriteDropped
);

  localparam logic [ADDR_WIDTH:0] SIZE = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0] LAST = SIZE - 1'b1;

  clr_state_t            state, state_n;
  logic [ADDR_WIDTH:0]   cnt, cnt_n;
  logic [DATA_WIDTH-1:0] color, color_n;

  logic                  wr_en, wr_go;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  drop_n, dropped;
  logic                  ext_ok, rd_ok, rd_zero;
  logic [DATA_WIDTH-1:0] core_q;

  assign ext_ok = iWriteEnable && ({1'b0, iWriteAddress} < SIZE);
  assign rd_ok  = {1'b0, iReadAddress} < SIZE;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    color_n = color;
    wr_en   = 1'b0;
    wr_addr = iWriteAddress;
    wr_data = iDataIn;
    drop_n  = 1'b0;
    unique case (1'b1)
      (state == CLEAR): begin
        wr_en   = 1'b1;
        wr_addr = cnt[ADDR_WIDTH-1:0];
        wr_data = color;
        cnt_n   = cnt + 1'b1;
        drop_n  = iWriteEnable;
        if (cnt == LAST)
          state_n = DONE;
      end
      default: begin
        // DONE behaves like IDLE for writes and new requests
        wr_en   = ext_ok;
        state_n = IDLE;
        if (iClearRequest) begin
          state_n = CLEAR;
          cnt_n   = '0;
          color_n = iClearColor;
        end
      end
    endcase
  end

  // reset aborts the sweep before the in-flight word lands
  assign wr_go = wr_en && !Reset;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      color   <= '0;
      dropped <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      color   <= color_n;
      dropped <= drop_n;
      rd_zero <= !rd_ok;
    end
  end

  video_ram_dp_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_SIZE   (MEM_SIZE)
  ) u_core (
    .Clock (Clock),
    .we    (wr_go),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (iReadAddress),
    .q     (core_q)
  );

`ifdef VIDEORAM_RD_BYPASS_EN
  logic                  byp_hit;
  logic [DATA_WIDTH-1:0] byp_data;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit  <= wr_go && (wr_addr == iReadAddress);
      byp_data <= wr_data;
    end
  end

  assign oDataOut = rd_zero ? '0 : (byp_hit ? byp_data : core_q);
`else
  assign oDataOut = rd_zero ? '0 : core_q;
`endif

  assign oClearBusy    = (state == CLEAR);
  assign oClearDone    = (state == DONE);
  assign oWriteDropped = dropped;

endmodule

// File: tb/tb_video_ram_clear.sv
// Randomised self-checking bench for video_ram_clear (3-bit, 12 words).
// Reference memory is a plain array updated from the behavioural rules.
module tb_video_ram_clear;

  localparam int DW = 3;
  localparam int AW = 4;
  localparam int MS = 12;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          iWriteEnable = 1'b0;
  logic [AW-1:0] iWriteAddress = '0;
  logic [DW-1:0] iDataIn = '0;
  logic [AW-1:0] iReadAddress = '0;
  logic [DW-1:0] oDataOut;
  logic          iClearRequest = 1'b0;
  logic [DW-1:0] iClearColor = '0;
  logic          oClearBusy;
  logic          oClearDone;
  logic          oWriteDropped;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [MS];
  bit            known   [MS];

  video_ram_clear #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_SIZE   (MS)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iWriteEnable  (iWriteEnable),
    .iWriteAddress (iWriteAddress),
    .iDataIn       (iDataIn),
    .iReadAddress  (iReadAddress),
    .oDataOut      (oDataOut),
    .iClearRequest (iClearRequest),
    .iClearColor   (iClearColor),
    .oClearBusy    (oClearBusy),
    .oClearDone    (oClearDone),
    .oWriteDropped (oWriteDropped)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick;
    tick;
    Reset = 1'b0;
    checks++;
    if (oClearBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", oClearBusy);
    end
    checks++;
    if (oClearDone !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %b want 0", oClearDone);
    end
    checks++;
    if (oWriteDropped !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop got %b want 0", oWriteDropped);
    end
    checks++;
    if (oDataOut !== '0) begin
      errors++;
      $display("FAIL reset_dout got %0d want 0", oDataOut);
    end
  endtask

  task automatic test_write_read;
    int a;
    logic [DW-1:0] d;
    iWriteEnable = 1'b1;
    iWriteAddress = 4'd7;
    iDataIn = 3'd5;
    tick;
    ref_mem[7] = 3'd5;
    known[7] = 1'b1;
    iWriteEnable = 1'b0;
    iReadAddress = 4'd7;
    tick;
    checks++;
    if (oDataOut !== 3'd5) begin
      errors++;
      $display("FAIL rd_addr7 got %0d want 5", oDataOut);
    end
    iReadAddress = 4'd13;
    tick;
    checks++;
    if (oDataOut !== '0) begin
      errors++;
      $display("FAIL rd_addr13 got %0d want 0", oDataOut);
    end
    for (int i = 0; i < 10; i++) begin
      a = $urandom_range(0, 15);
      d = DW'($urandom);
      iWriteEnable = 1'b1;
      iWriteAddress = a[AW-1:0];
      iDataIn = d;
      tick;
      if (a < MS) begin
        ref_mem[a] = d;
        known[a] = 1'b1;
      end
    end
    iWriteEnable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      iReadAddress = i[AW-1:0];
      tick;
      if (i >= MS || known[i]) begin
        checks++;
        if (oDataOut !== (i >= MS ? 3'd0 : ref_mem[i])) begin
          errors++;
          $display("FAIL rand_rd addr %0d got %0d want %0d", i, oDataOut,
                   (i >= MS ? 3'd0 : ref_mem[i]));
        end
      end
    end
  endtask

  task automatic test_clear(input logic [DW-1:0] col, input bit with_drop);
    int busy_n = 0;
    int done_n = 0;
    int drop_n = 0;
    int done_at = -1;
    iClearRequest = 1'b1;
    iClearColor = col;
    tick;
    iClearRequest = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (oClearBusy) busy_n++;
      if (oClearDone) begin
        done_n++;
        done_at = i;
      end
      if (oWriteDropped) drop_n++;
      iClearColor = DW'($urandom);
      iClearRequest = (i == 6);
      iWriteEnable = with_drop && (i == 4);
      iWriteAddress = 4'd3;
      iDataIn = 3'd7;
      tick;
    end
    iWriteEnable = 1'b0;
    iClearRequest = 1'b0;
    for (int a = 0; a < MS; a++) begin
      ref_mem[a] = col;
      known[a] = 1'b1;
    end
    checks++;
    if (busy_n != MS) begin
      errors++;
      $display("FAIL clr_busy_len got %0d want %0d", busy_n, MS);
    end
    checks++;
    if (done_n != 1 || done_at != MS) begin
      errors++;
      $display("FAIL clr_done got n=%0d at=%0d want n=1 at=%0d",
               done_n, done_at, MS);
    end
    checks++;
    if (drop_n != (with_drop ? 1 : 0)) begin
      errors++;
      $display("FAIL clr_dropped got %0d want %0d", drop_n, with_drop);
    end
    for (int a = 0; a < MS; a++) begin
      iReadAddress = a[AW-1:0];
      tick;
      checks++;
      if (oDataOut !== ref_mem[a]) begin
        errors++;
        $display("FAIL clr_rd addr %0d got %0d want %0d", a, oDataOut,
                 ref_mem[a]);
      end
    end
  endtask

  task automatic test_rd_during_wr;
    int a;
    logic [DW-1:0] d, old;
    logic [DW-1:0] want;
    iWriteEnable = 1'b1;
    iWriteAddress = 4'd4;
    iDataIn = 3'd1;
    tick;
    ref_mem[4] = 3'd1;
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 4 : $urandom_range(0, MS - 1);
      d = (i == 0) ? 3'd6 : DW'($urandom);
      old = ref_mem[a];
      iWriteEnable = 1'b1;
      iWriteAddress = a[AW-1:0];
      iReadAddress = a[AW-1:0];
      iDataIn = d;
      tick;
      ref_mem[a] = d;
`ifdef VIDEORAM_RD_BYPASS_EN
      want = d;
`else
      want = old;
`endif
      checks++;
      if (oDataOut !== want) begin
        errors++;
        $display("FAIL rdw addr %0d got %0d want %0d", a, oDataOut, want);
      end
      iWriteEnable = 1'b0;
      tick;
      checks++;
      if (oDataOut !== d) begin
        errors++;
        $display("FAIL rdw_after addr %0d got %0d want %0d", a, oDataOut, d);
      end
    end
  endtask

  task automatic test_reset_mid_clear;
    bit seen_done = 0;
    iClearRequest = 1'b1;
    iClearColor = 3'd3;
    tick;
    iClearRequest = 1'b0;
    repeat (5) tick;
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    for (int a = 0; a < MS; a++)
      ref_mem[a] = (a < 5) ? 3'd3 : 3'd0;
    checks++;
    if (oClearBusy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_busy got %b want 0", oClearBusy);
    end
    for (int i = 0; i < MS + 4; i++) begin
      if (oClearDone) seen_done = 1;
      tick;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL rstmid_done got pulse want none");
    end
    for (int a = 0; a < MS; a++) begin
      iReadAddress = a[AW-1:0];
      tick;
      checks++;
      if (oDataOut !== ref_mem[a]) begin
        errors++;
        $display("FAIL rstmid_rd addr %0d got %0d want %0d", a, oDataOut,
                 ref_mem[a]);
      end
    end
  endtask

  task automatic test_held_request;
    logic [DW-1:0] col;
    int done_n = 0;
    int d1 = -1;
    int d2 = -1;
    bit finished = 0;
    col = DW'($urandom);
    iClearColor = col;
    iClearRequest = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick;
      if (oClearDone) begin
        done_n++;
        if (done_n == 1) d1 = i;
        else if (done_n == 2) d2 = i;
      end
    end
    iClearRequest = 1'b0;
    for (int i = 0; i < 2 * MS && !finished; i++) begin
      tick;
      if (oClearDone) finished = 1;
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL held_drain got no done want done");
    end
    checks++;
    if (done_n != 2 || d1 != MS + 1 || d2 != 2 * MS + 2) begin
      errors++;
      $display("FAIL held_done got n=%0d at %0d,%0d want n=2 at %0d,%0d",
               done_n, d1, d2, MS + 1, 2 * MS + 2);
    end
    for (int a = 0; a < MS; a++)
      ref_mem[a] = col;
    for (int a = 0; a < MS; a++) begin
      iReadAddress = a[AW-1:0];
      tick;
      checks++;
      if (oDataOut !== ref_mem[a]) begin
        errors++;
        $display("FAIL held_rd addr %0d got %0d want %0d", a, oDataOut,
                 ref_mem[a]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < MS; a++) begin
      ref_mem[a] = '0;
      known[a] = 1'b0;
    end
    test_reset;
    test_write_read;
    test_clear(3'd2, 1'b1);
    test_clear(DW'($urandom), 1'b0);
    test_rd_during_wr;
    test_clear(3'd0, 1'b0);
    test_reset_mid_clear;
    test_held_request;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
